// File: rtl/sram_timer_pkg.sv
// Shared definitions for the sram_timer slave: register offsets, CTRL bits,
// reset constants and the byte-lane merge used by SRAM-style slaves.
package sram_timer_pkg;

  localparam logic [2:0] REG_MTIME    = 3'd0;
  localparam logic [2:0] REG_MTIMECMP = 3'd1;
  localparam logic [2:0] REG_CTRL     = 3'd2;
  localparam logic [2:0] REG_PRESCALE = 3'd3;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_IRQ_MASK_N = 1;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Byte lane k of the result comes from new_val when wea[k] is set.
  function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  wea);
    logic [63:0] res;
    res = old_val;
    for (int k = 0; k < 8; k++) begin
      if (wea[k]) res[8*k +: 8] = new_val[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for sram_timer: pulses tick once every (div+1) enabled clocks.
// Only instantiated when TIMER_PRESCALE_EN is defined.
module timer_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] div,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] cnt_d;

  assign tick = en && (cnt_q == div);

  // clr wins over counting but does not suppress a tick due this cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sram_timer.sv
// Memory-mapped mtime/mtimecmp timer on the 64-bit SRAM-style slave port.
// Optional prescaler is built only when TIMER_PRESCALE_EN is defined.
module sram_timer
  import sram_timer_pkg::*;
#(
  parameter int ADDR_LSB   = 3,
  parameter int CLK_HZ     = 100000000,
  parameter int PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] addra,
  input  logic [63:0] dina,
  output logic [63:0] douta,
  input  logic        ena,
  input  logic [7:0]  wea,
  output logic        timer_irq
);

  localparam int unused_clk_hz = CLK_HZ;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [63:0] douta_q, douta_d;
  logic        irq_q, irq_d;

  logic [2:0]  sel;
  logic        wr, rd, tick;
  logic [63:0] mtime_inc;
  logic [63:0] rdata;
  logic        unused_addr;

  assign sel         = addra[ADDR_LSB +: 3];
  assign wr          = ena && (wea != 8'h00);
  assign rd          = ena && (wea == 8'h00);
  assign unused_addr = ^{addra[63:ADDR_LSB+3], addra[ADDR_LSB-1:0]};

`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;

  timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ctrl_q[CTRL_EN]),
    .clr   (wr && ((sel == REG_MTIME) || (sel == REG_PRESCALE))),
    .div   (prescale_q),
    .tick  (tick)
  );

  always_comb begin
    prescale_d = prescale_q;
    if (wr && (sel == REG_PRESCALE)) begin
      for (int b = 0; b < PRESCALE_W; b++) begin
        if (wea[b/8]) prescale_d[b] = dina[b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) prescale_q <= '0;
    else        prescale_q <= prescale_d;
  end
`else
  localparam int unused_prescale_w = PRESCALE_W;
  assign tick = ctrl_q[CTRL_EN];
`endif

  always_comb begin
    mtime_inc = tick ? (mtime_q + 64'd1) : mtime_q;

    // Unwritten lanes of MTIME still advance when a tick lands on a write.
    mtime_d = mtime_inc;
    if (wr && (sel == REG_MTIME)) mtime_d = byte_merge(mtime_inc, dina, wea);

    mtimecmp_d = mtimecmp_q;
    if (wr && (sel == REG_MTIMECMP)) mtimecmp_d = byte_merge(mtimecmp_q, dina, wea);

    ctrl_d = ctrl_q;
    if (wr && (sel == REG_CTRL) && wea[0]) ctrl_d = dina[1:0];

    rdata = 64'd0;
    case (sel)
      REG_MTIME:    rdata = mtime_q;
      REG_MTIMECMP: rdata = mtimecmp_q;
      REG_CTRL:     rdata = {62'd0, ctrl_q};
`ifdef TIMER_PRESCALE_EN
      REG_PRESCALE: rdata = {{(64-PRESCALE_W){1'b0}}, prescale_q};
`endif
      default:      rdata = 64'd0;
    endcase

    douta_d = rd ? rdata : douta_q;

    // Compare against next-state values so irq tracks the registers with no lag.
    irq_d = ctrl_d[CTRL_EN] & ctrl_d[CTRL_IRQ_MASK_N] & (mtime_d >= mtimecmp_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= MTIMECMP_RST;
      ctrl_q     <= 2'b00;
      douta_q    <= 64'd0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      ctrl_q     <= ctrl_d;
      douta_q    <= douta_d;
      irq_q      <= irq_d;
    end
  end

  assign douta     = douta_q;
  assign timer_irq = irq_q;

endmodule
